bcd_digit_sequencer: RTL and testbench



---
 rtl/seg_pkg.sv | 12 +
 rtl/seg_prescaler.sv | 28 ++
 rtl/bcd_digit_sequencer.sv | 82 ++++++++
 tb/tb_bcd_digit_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared BCD types and helpers for the digit sequencer and the segment decoder stages.
// Pure declarations: no logic, no latency.
package seg_pkg;
  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  function automatic logic is_bcd(input bcd_t v);
    return (v <= BCD_MAX);
  endfunction
endpackage

// File: rtl/seg_prescaler.sv
// DWELL-cycle enable divider: tick is a combinational strobe on the enabled cycle the count reaches DWELL-1.
// Holds its count while en is low; clr restarts a full dwell and suppresses the tick.
module seg_prescaler #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = en & ~clr & w_last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/bcd_digit_sequencer.sv
// BCD digit source (0..9) with programmable dwell, up/down, load and carry for cascading.
// All outputs registered; first step lands DWELL enabled cycles after counting starts, en low freezes state.
module bcd_digit_sequencer
  import seg_pkg::*;
#(
  parameter int DWELL = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       step,
  output logic       carry,
  output logic       err
);
  bcd_t r_digit;
  logic r_step;
  logic r_carry;
  logic r_err;
  logic w_tick;

  seg_prescaler #(.DWELL(DWELL)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (w_tick)
  );

  // Wrap is an explicit compare-and-set so codes 10..15 can never be produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= BCD_MIN;
      r_step  <= 1'b0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_step  <= 1'b0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      if (load) begin
        if (is_bcd(load_val)) begin
          r_digit <= load_val;
        end else begin
          r_digit <= BCD_MIN;
          r_err   <= 1'b1;
        end
      end else if (w_tick) begin
        if (up) begin
          if (r_digit < BCD_MAX) begin
            r_digit <= r_digit + 4'd1;
            r_step  <= 1'b1;
          end else if (WRAP) begin
            r_digit <= BCD_MIN;
            r_step  <= 1'b1;
            r_carry <= 1'b1;
          end
        end else begin
          if (r_digit > BCD_MIN) begin
            r_digit <= r_digit - 4'd1;
            r_step  <= 1'b1;
          end else if (WRAP) begin
            r_digit <= BCD_MAX;
            r_step  <= 1'b1;
            r_carry <= 1'b1;
          end
        end
      end
    end
  end

  assign digit = r_digit;
  assign step  = r_step;
  assign carry = r_carry;
  assign err   = r_err;

  a_digit_bcd: assert property (@(posedge clk) is_bcd(r_digit));
endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Directed bench for bcd_digit_sequencer: DWELL=4 wrapping, DWELL=4 saturating and DWELL=1 wrapping instances.
module tb_bcd_digit_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       en2 = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] d0, d1, d2;
  logic       s0, s1, s2;
  logic       c0, c1, c2;
  logic       e0, e1, e2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_digit_sequencer #(.DWELL(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .digit(d0), .step(s0), .carry(c0), .err(e0)
  );

  bcd_digit_sequencer #(.DWELL(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .digit(d1), .step(s1), .carry(c1), .err(e1)
  );

  bcd_digit_sequencer #(.DWELL(1), .WRAP(1'b1)) u_fast (
    .clk(clk), .rst(rst), .en(en2), .up(up), .load(load), .load_val(load_val),
    .digit(d2), .step(s2), .carry(c2), .err(e2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1; en2 = 1'b1; up = 1'b1;
    tick();
    n_cmp++;
    if ({d0, s0, c0, e0} !== 7'b0) begin
      n_err++; $display("FAIL reset_u0: got d=%0d s=%b c=%b e=%b want 0/0/0/0", d0, s0, c0, e0);
    end
    n_cmp++;
    if ({d1, s1, c1, e1} !== 7'b0) begin
      n_err++; $display("FAIL reset_u1: got d=%0d s=%b c=%b e=%b want 0/0/0/0", d1, s1, c1, e1);
    end
    n_cmp++;
    if ({d2, s2, c2, e2} !== 7'b0) begin
      n_err++; $display("FAIL reset_u2: got d=%0d s=%b c=%b e=%b want 0/0/0/0", d2, s2, c2, e2);
    end
    rst = 1'b0; load = 1'b0; en = 1'b0; en2 = 1'b0;
  endtask

  task automatic test_count_up();
    logic [3:0] exp_d;
    logic       exp_s;
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_d = 4'(k / 4);
      exp_s = (k % 4 == 0);
      n_cmp++;
      if (d0 !== exp_d || s0 !== exp_s || c0 !== 1'b0) begin
        n_err++; $display("FAIL count_up k=%0d: got d=%0d s=%b c=%b want d=%0d s=%b c=0", k, d0, s0, c0, exp_d, exp_s);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap_up();
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0;
    n_cmp++;
    if (d0 !== 4'd9 || d1 !== 4'd9 || e0 !== 1'b0 || s0 !== 1'b0) begin
      n_err++; $display("FAIL load9: got d0=%0d d1=%0d e=%b s=%b want 9/9/0/0", d0, d1, e0, s0);
    end
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) begin
        n_cmp++;
        if (d0 !== 4'd9 || s0 !== 1'b0) begin
          n_err++; $display("FAIL wrap_dwell k=%0d: got d=%0d s=%b want 9/0", k, d0, s0);
        end
      end
    end
    n_cmp++;
    if (d0 !== 4'd0 || s0 !== 1'b1 || c0 !== 1'b1) begin
      n_err++; $display("FAIL wrap_up: got d=%0d s=%b c=%b want 0/1/1", d0, s0, c0);
    end
    n_cmp++;
    if (d1 !== 4'd9 || s1 !== 1'b0 || c1 !== 1'b0) begin
      n_err++; $display("FAIL sat_up: got d=%0d s=%b c=%b want 9/0/0", d1, s1, c1);
    end
    tick();
    n_cmp++;
    if (c0 !== 1'b0 || s0 !== 1'b0 || d0 !== 4'd0) begin
      n_err++; $display("FAIL carry_pulse_width: got d=%0d s=%b c=%b want 0/0/0", d0, s0, c0);
    end
    en = 1'b0;
  endtask

  task automatic test_load_err();
    load = 1'b1; load_val = 4'b1100;
    tick();
    load = 1'b0;
    n_cmp++;
    if (d0 !== 4'd0 || e0 !== 1'b1 || s0 !== 1'b0) begin
      n_err++; $display("FAIL load_bad: got d=%0d e=%b s=%b want 0/1/0", d0, e0, s0);
    end
    tick();
    n_cmp++;
    if (e0 !== 1'b0) begin
      n_err++; $display("FAIL err_pulse_width: got e=%b want 0", e0);
    end
    en = 1'b1; up = 1'b1;
    tick(); tick();
    load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0;
    n_cmp++;
    if (d0 !== 4'd7 || e0 !== 1'b0 || s0 !== 1'b0) begin
      n_err++; $display("FAIL load7: got d=%0d e=%b s=%b want 7/0/0", d0, e0, s0);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++;
      if (k < 4) begin
        if (d0 !== 4'd7 || s0 !== 1'b0) begin
          n_err++; $display("FAIL load_dwell k=%0d: got d=%0d s=%b want 7/0", k, d0, s0);
        end
      end else if (d0 !== 4'd8 || s0 !== 1'b1) begin
        n_err++; $display("FAIL load_step: got d=%0d s=%b want 8/1", d0, s0);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap_and_en_gap();
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; up = 1'b0; en = 1'b1;
    tick(); tick(); tick(); tick();
    n_cmp++;
    if (d0 !== 4'd9 || s0 !== 1'b1 || c0 !== 1'b1) begin
      n_err++; $display("FAIL wrap_down: got d=%0d s=%b c=%b want 9/1/1", d0, s0, c0);
    end
    n_cmp++;
    if (d1 !== 4'd0 || s1 !== 1'b0 || c1 !== 1'b0) begin
      n_err++; $display("FAIL sat_down: got d=%0d s=%b c=%b want 0/0/0", d1, s1, c1);
    end
    tick(); tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (d0 !== 4'd9 || s0 !== 1'b0) begin
        n_err++; $display("FAIL en_low k=%0d: got d=%0d s=%b want 9/0", k, d0, s0);
      end
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if (d0 !== 4'd9 || s0 !== 1'b0) begin
      n_err++; $display("FAIL en_resume: got d=%0d s=%b want 9/0", d0, s0);
    end
    tick();
    n_cmp++;
    if (d0 !== 4'd8 || s0 !== 1'b1 || c0 !== 1'b0) begin
      n_err++; $display("FAIL en_gap_step: got d=%0d s=%b c=%b want 8/1/0", d0, s0, c0);
    end
    en = 1'b0;
  endtask

  task automatic test_rst_mid();
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0; up = 1'b1; en = 1'b1;
    tick(); tick(); tick(); tick();
    n_cmp++;
    if (d0 !== 4'd6 || s0 !== 1'b1) begin
      n_err++; $display("FAIL pre_rst_step: got d=%0d s=%b want 6/1", d0, s0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (d0 !== 4'd0 || s0 !== 1'b0 || c0 !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_pulse: got d=%0d s=%b c=%b want 0/0/0", d0, s0, c0);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++;
      if (k < 4) begin
        if (d0 !== 4'd0 || s0 !== 1'b0) begin
          n_err++; $display("FAIL rst_dwell k=%0d: got d=%0d s=%b want 0/0", k, d0, s0);
        end
      end else if (d0 !== 4'd1 || s0 !== 1'b1) begin
        n_err++; $display("FAIL rst_first_step: got d=%0d s=%b want 1/1", d0, s0);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_dwell1();
    logic [3:0] exp_d;
    logic       exp_c;
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; en2 = 1'b1; up = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_d = 4'(k % 10);
      exp_c = (k % 10 == 0);
      n_cmp++;
      if (d2 !== exp_d || s2 !== 1'b1 || c2 !== exp_c) begin
        n_err++; $display("FAIL dwell1 k=%0d: got d=%0d s=%b c=%b want d=%0d s=1 c=%b", k, d2, s2, c2, exp_d, exp_c);
      end
    end
    en2 = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      en       = 1'($urandom);
      en2      = 1'($urandom);
      up       = 1'($urandom);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 4'($urandom_range(0, 15));
      tick();
      n_cmp++;
      if (d0 > 4'd9 || d1 > 4'd9 || d2 > 4'd9) begin
        n_err++; $display("FAIL random_range i=%0d: got d0=%0d d1=%0d d2=%0d want all <=9", i, d0, d1, d2);
      end
    end
    rst = 1'b1; en = 1'b0; en2 = 1'b0; load = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_load_err();
    test_down_wrap_and_en_gap();
    test_rst_mid();
    test_dwell1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
